// File: rtl/hazard_stall_controller_pkg.sv
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and constants for the hazard stall controller:
//                FSM state encoding, instruction field slice positions and
//                the hardwired-zero register index.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    typedef enum logic {
        ST_RUN         = 1'b0,
        ST_MULDIV_WAIT = 1'b1
    } state_e;

    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

`default_nettype wire

// File: rtl/hazard_stall_controller_counter.sv
// ============================================================================
//  Module      : muldiv_stall_counter
//  Description : Down-counter tracking the remaining frozen cycles of a
//                multi-cycle mult/div. Loaded with LOAD_VAL, decremented on
//                request while non-zero, never wraps.
//  Ports       : clk     - clock, rising edge
//                rst_n   - asynchronous active-low reset (counter -> 0)
//                load_i  - load LOAD_VAL (has priority over dec_i)
//                dec_i   - decrement by one when counter is non-zero
//                last_o  - counter currently equals 1 (final frozen cycle)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_stall_counter #(
    parameter int CNT_W    = 4,
    parameter int LOAD_VAL = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic dec_i,
    output logic last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(LOAD_VAL);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/hazard_stall_controller.sv
// ============================================================================
//  Module      : hazard_stall_controller
//  Description : Hazard sequencer for the 5-stage MIPS pipeline. Handles
//                load-use stalls, taken-branch flushes and front-end freeze
//                during multi-cycle mult/div. Outputs are combinational from
//                state and current inputs.
//  Ports       : clk, reset (async, active-low)
//                ID_Instruction_In, EX_MemRead_In, EX_WriteRegister_In,
//                EX_Branch_Taken_In, EX_MulDiv_Start_In       - hazard inputs
//                PC_Write_Out, IFID_Write_Out, IFID_Flush_Out,
//                IDEX_Write_Out, IDEX_Bubble_Out, EXMEM_Bubble_Out - controls
//                State_Out                                    - 0=RUN, 1=WAIT
//  Options     : HAZARD_STATS_EN adds Stall_Count_Out / Flush_Count_Out
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int MULDIV_LATENCY = 4,
    parameter int CNT_W          = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ID_Instruction_In,
    input  logic        EX_MemRead_In,
    input  logic [4:0]  EX_WriteRegister_In,
    input  logic        EX_Branch_Taken_In,
    input  logic        EX_MulDiv_Start_In,
    output logic        PC_Write_Out,
    output logic        IFID_Write_Out,
    output logic        IFID_Flush_Out,
    output logic        IDEX_Write_Out,
    output logic        IDEX_Bubble_Out,
    output logic        EXMEM_Bubble_Out,
`ifdef HAZARD_STATS_EN
    output logic [31:0] Stall_Count_Out,
    output logic [31:0] Flush_Count_Out,
`endif
    output logic        State_Out
);

    state_e state_q;
    state_e state_d;
    logic   w_load_use;
    logic   w_cnt_load;
    logic   w_cnt_dec;
    logic   w_cnt_last;
    logic   w_unused_instr_bits;

    // rt is compared even for instructions that do not read it; a spurious
    // one-cycle stall is cheaper than decoding the opcode here.
    assign w_load_use = EX_MemRead_In
                     && (EX_WriteRegister_In != REG_ZERO)
                     && ((EX_WriteRegister_In == ID_Instruction_In[RS_HI:RS_LO])
                      || (EX_WriteRegister_In == ID_Instruction_In[RT_HI:RT_LO]));

    assign w_unused_instr_bits = ^{ID_Instruction_In[31:26], ID_Instruction_In[15:0]};

    muldiv_stall_counter #(
        .CNT_W    (CNT_W),
        .LOAD_VAL (MULDIV_LATENCY - 1)
    ) u_muldiv_cnt (
        .clk    (clk),
        .rst_n  (reset),
        .load_i (w_cnt_load),
        .dec_i  (w_cnt_dec),
        .last_o (w_cnt_last)
    );

    always_comb begin
        state_d          = state_q;
        w_cnt_load       = 1'b0;
        w_cnt_dec        = 1'b0;
        PC_Write_Out     = 1'b1;
        IFID_Write_Out   = 1'b1;
        IDEX_Write_Out   = 1'b1;
        IFID_Flush_Out   = 1'b0;
        IDEX_Bubble_Out  = 1'b0;
        EXMEM_Bubble_Out = 1'b0;

        if (!reset) begin
            // Hold the whole pipe empty and frozen while reset is asserted.
            PC_Write_Out     = 1'b0;
            IFID_Write_Out   = 1'b0;
            IDEX_Write_Out   = 1'b0;
            IFID_Flush_Out   = 1'b1;
            IDEX_Bubble_Out  = 1'b1;
            EXMEM_Bubble_Out = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (EX_Branch_Taken_In) begin
                        // The ID instruction is squashed, so its hazards and
                        // any mult/div start behind the branch do not matter.
                        IFID_Flush_Out  = 1'b1;
                        IDEX_Bubble_Out = 1'b1;
                    end else if (EX_MulDiv_Start_In) begin
                        PC_Write_Out     = 1'b0;
                        IFID_Write_Out   = 1'b0;
                        IDEX_Write_Out   = 1'b0;
                        EXMEM_Bubble_Out = 1'b1;
                        w_cnt_load       = 1'b1;
                        state_d          = ST_MULDIV_WAIT;
                    end else if (w_load_use) begin
                        PC_Write_Out    = 1'b0;
                        IFID_Write_Out  = 1'b0;
                        IDEX_Bubble_Out = 1'b1;
                    end
                end
                ST_MULDIV_WAIT: begin
                    PC_Write_Out     = 1'b0;
                    IFID_Write_Out   = 1'b0;
                    IDEX_Write_Out   = 1'b0;
                    EXMEM_Bubble_Out = 1'b1;
                    w_cnt_dec        = 1'b1;
                    if (w_cnt_last) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign State_Out = state_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!PC_Write_Out && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (IFID_Flush_Out && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign Stall_Count_Out = stall_cnt_q;
    assign Flush_Count_Out = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline hazard sequencer for the 5-stage MIPS core. It sits beside the forwarding unit and covers the hazards that forwarding cannot resolve.
- Detects load-use hazards in ID and issues a 1-cycle stall with an ID/EX bubble.
- Flushes IF/ID and ID/EX when a branch resolves taken in EX.
- Freezes the front of the pipe while a multi-cycle mult/div occupies EX.
- Drives the write-enables and bubble/flush controls of PC, IF/ID, ID/EX and EX/MEM.

Parameters:
- MULDIV_LATENCY, 4: total EX cycles of a mult/div including its first cycle. Legal range is 2..15.
- CNT_W, 4: width of the mult/div down-counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ID_Instruction_In  in  32  instruction in ID; rs=[25:21], rt=[20:16].
- EX_MemRead_In  in  1  instruction in EX is a load.
- EX_WriteRegister_In  in  5  destination register of the EX instruction.
- EX_Branch_Taken_In  in  1  branch in EX resolved taken.
- EX_MulDiv_Start_In  in  1  a mult/div entered EX this cycle; asserted in its first EX cycle only.
- PC_Write_Out  out  1  PC load enable.
- IFID_Write_Out  out  1  IF/ID load enable.
- IFID_Flush_Out  out  1  clear IF/ID to NOP.
- IDEX_Write_Out  out  1  ID/EX load enable.
- IDEX_Bubble_Out  out  1  load NOP into ID/EX.
- EXMEM_Bubble_Out  out  1  load NOP into EX/MEM.
- State_Out  out  1  0=RUN, 1=MULDIV_WAIT (debug).

Behaviour:
- Clock and reset: single clock. Reset is asynchronous and active-low.
- While reset=0:
  - State is RUN and the counter is 0.
  - Outputs are forced to PC_Write=0, IFID_Write=0, IDEX_Write=0, IFID_Flush=1, IDEX_Bubble=1, EXMEM_Bubble=1.
  - Reset asserted mid-operation aborts any MULDIV_WAIT immediately.
- Outputs are combinational from state and current inputs (zero latency). The stall must take effect in the same cycle the hazard is seen.
- Default outputs (no event): PC_Write=IFID_Write=IDEX_Write=1, all flush/bubble outputs 0.
- Load-use hazard (LU): EX_MemRead_In=1, EX_WriteRegister_In!=0, and EX_WriteRegister_In equals rs or rt of ID_Instruction_In.
  - rt is compared unconditionally; this is conservative.
  - Response: PC_Write=0, IFID_Write=0, IDEX_Bubble=1.
  - The stall lasts exactly one cycle because the load advances to MEM; no state is kept.
- RUN, priority order:
  1. EX_Branch_Taken_In=1: IFID_Flush=1 and IDEX_Bubble=1, PC_Write=1. LU is ignored because the ID instruction is squashed. EX_MulDiv_Start_In in the same cycle is ignored. Stay in RUN.
  2. EX_MulDiv_Start_In=1:
     - PC_Write=0, IFID_Write=0, IDEX_Write=0, EXMEM_Bubble=1.
     - Load counter with MULDIV_LATENCY-1 and go to MULDIV_WAIT.
     - LU is suppressed; it is re-evaluated after release.
  3. LU: load-use stall as above.
- MULDIV_WAIT:
  - Outputs: PC_Write=0, IFID_Write=0, IDEX_Write=0, EXMEM_Bubble=1.
  - Counter decrements each cycle.
  - When counter==1 at a clock edge, go to RUN with counter 0. This is the last frozen cycle.
  - Branch, mult/div-start and LU inputs are ignored in this state.
- Net effect: EX_MulDiv_Start plus MULDIV_WAIT gives MULDIV_LATENCY frozen cycles in total.
- Back-to-back: a mult/div whose start is seen in the first RUN cycle after release re-enters MULDIV_WAIT with no gap.
- Counter arithmetic is unsigned CNT_W-bit. It never wraps: decrement happens only in MULDIV_WAIT with counter>=1.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, adds outputs Stall_Count_Out[31:0] and Flush_Count_Out[31:0]:
  - Stall_Count_Out increments on each non-reset cycle with PC_Write_Out=0.
  - Flush_Count_Out increments on each cycle with IFID_Flush_Out=1 and reset=1.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - State encodings ST_RUN=1'b0 and ST_MULDIV_WAIT=1'b1.
  - Field-slice constants RS_HI/RS_LO/RT_HI/RT_LO.
  - REG_ZERO=5'd0.
- One sub-module, muldiv_stall_counter: load, decrement and last-cycle flag. It owns the counter register and CNT_W.

Test Plan:
- Reset held low 3 cycles, then released → all outputs at the reset values while low; the default values appear the first cycle after release.
- EX: lw writes $8 (EX_MemRead=1, EX_WriteRegister=8); ID: add $9,$8,$10 (rs=8) → exactly 1 cycle of PC_Write=0, IFID_Write=0, IDEX_Bubble=1. Repeat with EX_WriteRegister=0 → no stall.
- EX_MulDiv_Start=1 with MULDIV_LATENCY=4 → PC_Write=0 and EXMEM_Bubble=1 for exactly 4 consecutive cycles; State_Out=1 for the last 3; RUN on the 5th.
- Same cycle EX_Branch_Taken=1 with LU on ID rs, and separately with EX_MulDiv_Start=1 → IFID_Flush=1, IDEX_Bubble=1, PC_Write=1, no stall, State_Out stays 0.
- Reset driven low during the 2nd MULDIV_WAIT cycle → State_Out=0 immediately (asynchronous); after release, no residual stall.
- With HAZARD_STATS_EN: one LU, one 4-cycle mult/div, and two taken branches → Stall_Count_Out=5, Flush_Count_Out=2.
